// File: rtl/dot_pkg.sv
// Shared defaults, state encoding and beat-counter helpers for the dot-product sequencer.
package dot_pkg;

    localparam int data_width_dflt = 8;
    localparam int para_deg_dflt   = 3;
    localparam int beat_w          = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        DRAIN  = 3'd2,
        REDUCE = 3'd3,
        OUT    = 3'd4
    } state_t;

    function automatic logic [beat_w-1:0] sat_inc(input logic [beat_w-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dot_sequencer_if.sv
// Bus bundle between the dot-product sequencer, its beat source, its result sink and the PEGroup.
interface dot_sequencer_if
    import dot_pkg::*;
#(
    parameter int data_width = data_width_dflt,
    parameter int para_deg   = para_deg_dflt
);

    // Both streams: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload stable until that edge.
    logic                             in_valid;
    logic                             in_ready;
    logic [para_deg*data_width-1:0]   in_a;
    logic [para_deg*data_width-1:0]   in_b;
    logic                             in_last;

    logic [para_deg*data_width-1:0]   pe_data0;
    logic [para_deg*data_width-1:0]   pe_data1;
    logic                             pe_load_old_output;
    logic [para_deg*2*data_width-1:0] pe_old_output;
    logic [para_deg*2*data_width-1:0] pe_result;

    logic                             out_valid;
    logic                             out_ready;
    logic [2*data_width-1:0]          out_sum;
    logic [beat_w-1:0]                out_beats;

    modport slave (
        input  in_valid, in_a, in_b, in_last, pe_result, out_ready,
        output in_ready, pe_data0, pe_data1, pe_load_old_output, pe_old_output,
               out_valid, out_sum, out_beats
    );

    modport master (
        output in_valid, in_a, in_b, in_last, pe_result, out_ready,
        input  in_ready, pe_data0, pe_data1, pe_load_old_output, pe_old_output,
               out_valid, out_sum, out_beats
    );

endinterface

// File: rtl/dot_lane_reducer.sv
// Captures the PEGroup lane results and sums them serially, one lane per cycle.
module dot_lane_reducer
    import dot_pkg::*;
#(
    parameter int data_width = data_width_dflt,
    parameter int para_deg   = para_deg_dflt
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [para_deg*2*data_width-1:0] lanes,
    output logic [2*data_width-1:0]          sum,
    output logic                             done
);

    localparam int lw    = 2 * data_width;
    localparam int idx_w = (para_deg > 1) ? $clog2(para_deg) : 1;

    logic [para_deg*lw-1:0] lane_q;
    logic [lw-1:0]          acc;
    logic [idx_w-1:0]       idx;
    logic                   busy;

    // High during the cycle that performs the final addition.
    assign done = busy && (idx == idx_w'(para_deg - 1));
    assign sum  = acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= '0;
            acc    <= '0;
            idx    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            lane_q <= lanes;
            acc    <= '0;
            idx    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc <= acc + lane_q[int'(idx)*lw +: lw];
            if (done) begin
                busy <= 1'b0;
                idx  <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dot_sequencer.sv
// Streams operand beats into an external PEGroup, then reduces its lanes into one dot product.
module dot_sequencer
    import dot_pkg::*;
#(
    parameter int data_width = data_width_dflt,
    parameter int para_deg   = para_deg_dflt
) (
    input  logic             clk,
    input  logic             reset,
    dot_sequencer_if.slave   bus,
    output state_t           dbg_state
);

    state_t state;
    logic   accept;
    logic   red_start;
    logic   red_done;

    assign bus.in_ready = reset && (state == IDLE || state == ACCUM);
    assign accept       = bus.in_valid && bus.in_ready;

    // Bubbles in ACCUM feed zeros with feedback on, so the PE accumulators hold.
    assign bus.pe_data0           = accept ? bus.in_a : '0;
    assign bus.pe_data1           = accept ? bus.in_b : '0;
    assign bus.pe_load_old_output = reset && (state == ACCUM);
    assign bus.pe_old_output      = bus.pe_result;

    assign red_start = (state == DRAIN);
    assign dbg_state = state;

    dot_lane_reducer #(
        .data_width (data_width),
        .para_deg   (para_deg)
    ) u_reducer (
        .clk   (clk),
        .reset (reset),
        .start (red_start),
        .lanes (bus.pe_result),
        .sum   (bus.out_sum),
        .done  (red_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_beats <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.out_beats <= beat_w'(1);
                        state         <= bus.in_last ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        bus.out_beats <= sat_inc(bus.out_beats);
                        if (bus.in_last) state <= DRAIN;
                    end
                end
                DRAIN: state <= REDUCE;
                REDUCE: begin
                    if (red_done) begin
                        state         <= OUT;
                        bus.out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_sequencer.sv
// Directed bench for dot_sequencer with a behavioural registered PEGroup.
module tb_dot_sequencer;
    import dot_pkg::*;

    localparam int dw = 8;
    localparam int pd = 3;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    state_t dbg_state;
    int     errors = 0;
    int     checks = 0;
    int     lat;

    always #5 clk = ~clk;

    dot_sequencer_if #(.data_width(dw), .para_deg(pd)) bus ();

    dot_sequencer #(.data_width(dw), .para_deg(pd)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // PEGroup: registered, latency 1, lane = (load ? old : 0) + d0 * d1.
    logic [pd*2*dw-1:0] pe_next;
    always_comb begin
        pe_next = '0;
        for (int i = 0; i < pd; i++) begin
            pe_next[2*dw*i +: 2*dw] =
                (bus.pe_load_old_output ? bus.pe_old_output[2*dw*i +: 2*dw] : 16'd0) +
                ({8'd0, bus.pe_data0[dw*i +: dw]} * {8'd0, bus.pe_data1[dw*i +: dw]});
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus.pe_result <= '0;
        else        bus.pe_result <= pe_next;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic last,
                        input logic exp_load);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        #1;
        check("in_ready_beat", 32'(bus.in_ready), 32'd1);
        check("pe_data0_echo", 32'(bus.pe_data0), 32'(a));
        check("pe_data1_echo", 32'(bus.pe_data1), 32'(b));
        check("pe_load_beat", 32'(bus.pe_load_old_output), 32'(exp_load));
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
    endtask

    task automatic bubble();
        #1;
        check("pe_load_bubble", 32'(bus.pe_load_old_output), 32'd1);
        check("pe_data0_bubble", 32'(bus.pe_data0), 32'd0);
        step();
    endtask

    // Cycles from the one after the last beat until out_valid rises.
    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        check("out_valid_after_consume", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_consume", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("rst_out_beats", 32'(bus.out_beats), 32'd0);
        check("rst_pe_load", 32'(bus.pe_load_old_output), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("rel_state", 32'(dbg_state), 32'(IDLE));
        step();

        // Single beat {1,2,3}.{4,5,6}: 4+10+18 = 32; out_valid at t+5
        send({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 1'b1, 1'b0);
        check("drain_pe_data0", 32'(bus.pe_data0), 32'd0);
        wait_out(lat);
        check("latency_single", 32'(lat), 32'd4);
        check("sum_single", 32'(bus.out_sum), 32'd32);
        check("beats_single", 32'(bus.out_beats), 32'd1);
        consume();

        // Two beats with bubbles: 3*(1*2) + 3*(3*3) = 33
        send({8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2}, 1'b0, 1'b0);
        check("state_accum", 32'(dbg_state), 32'(ACCUM));
        bubble();
        bubble();
        send({8'd3, 8'd3, 8'd3}, {8'd3, 8'd3, 8'd3}, 1'b1, 1'b1);
        wait_out(lat);
        check("latency_two", 32'(lat), 32'd4);
        check("sum_two", 32'(bus.out_sum), 32'd33);
        check("beats_two", 32'(bus.out_beats), 32'd2);
        consume();

        // All lanes 255*255: 195075 mod 65536 = 64003, then back-pressure for 5 cycles
        send({8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255}, 1'b1, 1'b0);
        wait_out(lat);
        check("sum_max", 32'(bus.out_sum), 32'd64003);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out_sum", 32'(bus.out_sum), 32'd64003);
            check("hold_out_beats", 32'(bus.out_beats), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        consume();

        // Reset during REDUCE discards the vector
        send({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 1'b1, 1'b0);
        step();
        check("state_reduce", 32'(dbg_state), 32'(REDUCE));
        bus.in_valid = 1'b1;
        bus.in_a     = {8'd7, 8'd7, 8'd7};
        bus.in_b     = {8'd7, 8'd7, 8'd7};
        reset        = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_sum", 32'(bus.out_sum), 32'd0);
        check("midrst_out_beats", 32'(bus.out_beats), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_pe_data0", 32'(bus.pe_data0), 32'd0);
        check("midrst_pe_load", 32'(bus.pe_load_old_output), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_no_result", 32'(bus.out_valid), 32'd0);
        end
        send({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 1'b1, 1'b0);
        wait_out(lat);
        check("sum_after_rst", 32'(bus.out_sum), 32'd32);
        check("beats_after_rst", 32'(bus.out_beats), 32'd1);
        consume();

        // 300 zero beats: counter saturates at 255
        send('0, '0, 1'b0, 1'b0);
        for (int i = 1; i < 299; i++) send('0, '0, 1'b0, 1'b1);
        send('0, '0, 1'b1, 1'b1);
        wait_out(lat);
        check("beats_sat", 32'(bus.out_beats), 32'd255);
        check("sum_zero", 32'(bus.out_sum), 32'd0);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dot_sequencer.md
DOT_SEQUENCER -- requirements
Module: dot_sequencer

Interface
REQ-001 Parameter data_width, default 8, meaning operand lane width in bits.
REQ-002 Parameter para_deg, default 3, meaning lane count of the attached PEGroup.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 in_valid  input  1  input beat offered.
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 in_a, in_b  input  para_deg*data_width each  operand lanes; lane i at [i*data_width +: data_width].
REQ-008 in_last  input  1  final beat of the current vector.
REQ-009 pe_data0, pe_data1  output  para_deg*data_width each  operands to the PEGroup.
REQ-010 pe_load_old_output  output  1  PEGroup adds pe_old_output when 1.
REQ-011 pe_old_output  output  para_deg*2*data_width  accumulator feedback to the PEGroup.
REQ-012 pe_result  input  para_deg*2*data_width  PEGroup lane results; lane i at [2*i*data_width +: 2*data_width].
REQ-013 out_valid  output  1  dot-product result available.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 out_sum  output  2*data_width  dot product, modulo 2^(2*data_width).
REQ-016 out_beats  output  8  beats in the vector, saturating at 255.

Function
REQ-017 PEGroup contract: registered, latency 1; lane result = (pe_load_old_output ? old lane : 0) + data0 lane * data1 lane, modulo 2^(2*data_width).
REQ-018 States IDLE, ACCUM, DRAIN, REDUCE, OUT; in_ready = 1 only in IDLE and ACCUM.
REQ-019 Accepted beat: pe_data0 = in_a, pe_data1 = in_b, combinationally in the acceptance cycle.
REQ-020 pe_load_old_output = 0 on the first beat of a vector (accepted in IDLE) and 1 on every later beat.
REQ-021 pe_old_output = pe_result at all times.
REQ-022 Bubble in ACCUM (in_valid = 0): pe_data0 = pe_data1 = 0 and pe_load_old_output = 1, so the PE accumulators hold their value.
REQ-023 In IDLE and in every state after ACCUM, pe_data0 = pe_data1 = 0 and pe_load_old_output = 0.
REQ-024 Transitions:
- IDLE -> ACCUM on an accepted beat without in_last.
- IDLE or ACCUM -> DRAIN on an accepted beat with in_last.
- DRAIN -> REDUCE after 1 cycle.
- REDUCE -> OUT after para_deg cycles.
- OUT -> IDLE on out_valid && out_ready.
REQ-025 DRAIN cycle: capture all pe_result lanes into a lane register; clear the reduction accumulator.
REQ-026 REDUCE cycle k (k = 0..para_deg-1): accumulator += lane k, wrapping at 2*data_width.
REQ-027 Latency: last beat accepted at cycle t gives out_valid = 1 from cycle t+2+para_deg.
REQ-028 out_sum and out_beats are registered and held stable while out_valid && !out_ready.
REQ-029 Beat counter: loaded to 1 on the first beat, incremented per accepted beat, saturating at 255.
REQ-030 A single-beat vector (in_last on the first beat) is legal.

Reset
REQ-031 reset low forces IDLE asynchronously: out_valid = 0, out_sum = 0, out_beats = 0, lane register and accumulator = 0.
REQ-032 While reset is low: in_ready = 0, pe_data0 = pe_data1 = 0, pe_load_old_output = 0.
REQ-033 Reset mid-vector discards the vector; no partial result is emitted, and in_ready = 1 on the first cycle after release.

Structure
REQ-034 Package dot_pkg holds the data_width and para_deg defaults, the state encoding and the beat-counter width.
REQ-035 The lane capture and serial summation are one sub-module, dot_lane_reducer (start, lanes in, sum out, done).

Verification (para_deg = 3, data_width = 8; bench includes a behavioural PEGroup)
REQ-036 One beat a = {1,2,3}, b = {4,5,6}, in_last -> out_sum = 32, out_beats = 1, out_valid at t+5.
REQ-037 Beat {1,1,1}x{2,2,2}, 2 bubble cycles, then {3,3,3}x{3,3,3} with in_last -> out_sum = 33, out_beats = 2.
REQ-038 One beat with all lanes 255x255 -> out_sum = 64003 (195075 mod 65536).
REQ-039 out_ready held low 5 cycles in OUT -> out_valid, out_sum and out_beats stable, in_ready = 0; one cycle after release, in_ready = 1.
REQ-040 reset pulsed low during REDUCE -> all outputs 0 immediately; next vector {1,2,3}x{4,5,6} -> out_sum = 32.
REQ-041 300 zero beats, last with in_last -> out_beats = 255, out_sum = 0.
